cv32e40p_data_port_arbiter: RTL and testbench

//  Shares the single mm_ram data port between two OBI-style requesters: the core
//  LSU (master 0) and the data cache refill/write-back engine (master 1).
//  - Arbitrates requests round-robin and muxes the address/write channel.
//  - Records which master owns each granted transaction.
//  - Routes each in-order response (rvalid/rdata) back to that master.

---
 rtl/cv32e40p_data_port_arbiter.sv | 125 ++++++++++++
 tb/tb_cv32e40p_data_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_data_port_arbiter.sv
// rtl/cv32e40p_data_port_arbiter.sv - two-master round-robin arbiter for the mm_ram data port
//
// Shares one OBI-style memory data port between the LSU (master 0) and the
// data cache refill/write-back engine (master 1). Grants alternate between the
// masters when both request. A small owner FIFO records which master each
// granted transaction belongs to, so in-order responses go back to that master.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   m_req_i/addr/we/be/wdata      per-master request channel (master n in slice n)
//   m_gnt_o, m_rvalid_o           per-master grant / response valid
//   m_rdata_o                     shared response data, qualified by m_rvalid_o
//   mem_req_o/addr/we/be/wdata    selected request towards memory
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i   memory handshake and response
//   outstanding_o                 granted-but-unanswered transaction count
//   err_o                         sticky: response seen with nothing outstanding
module cv32e40p_data_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  m_req_i,
  input  logic [63:0] m_addr_i,
  input  logic [1:0]  m_we_i,
  input  logic [7:0]  m_be_i,
  input  logic [63:0] m_wdata_i,
  output logic [1:0]  m_gnt_o,
  output logic [1:0]  m_rvalid_o,
  output logic [31:0] m_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  outstanding_o,
  output logic        err_o
);

  localparam int               PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [3:0]       MAX_CNT  = 4'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic             rr_ptr_q;
  logic             lock_q;
  logic             locked_id_q;
  logic             fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [3:0]       count_q;
  logic             err_q;

  logic       full;
  logic       empty;
  logic [1:0] eligible;
  logic       sel;
  logic       grant;
  logic       pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (count_q == MAX_CNT);
    empty    = (count_q == 4'd0);
    // A full FIFO blocks new grants even if a response frees a slot this cycle.
    eligible = m_req_i & ~{2{full}};

    // A stalled (ungranted) request keeps ownership of the port until granted.
    if (lock_q)          sel = locked_id_q;
    else if (&eligible)  sel = rr_ptr_q;
    else                 sel = eligible[1];

    mem_req_o   = eligible[sel] & ~rst_i;
    mem_addr_o  = sel ? m_addr_i[63:32]  : m_addr_i[31:0];
    mem_we_o    = sel ? m_we_i[1]        : m_we_i[0];
    mem_be_o    = sel ? m_be_i[7:4]      : m_be_i[3:0];
    mem_wdata_o = sel ? m_wdata_i[63:32] : m_wdata_i[31:0];

    grant   = mem_req_o & mem_gnt_i;
    m_gnt_o = 2'b00;
    if (grant) m_gnt_o[sel] = 1'b1;

    // Responses are in order, so the FIFO head always names the owner.
    pop        = mem_rvalid_i & ~empty & ~rst_i;
    m_rvalid_o = 2'b00;
    if (pop) m_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
    m_rdata_o  = mem_rdata_i;

    outstanding_o = count_q;
    err_o         = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= 1'b0;
      lock_q      <= 1'b0;
      locked_id_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      if (grant) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        rr_ptr_q         <= ~sel;
        lock_q           <= 1'b0;
      end else if (mem_req_o) begin
        lock_q      <= 1'b1;
        locked_id_q <= sel;
      end

      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

      count_q <= count_q + {3'b000, grant} - {3'b000, pop};

      if (mem_rvalid_i && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_data_port_arbiter.sv
// tb/tb_cv32e40p_data_port_arbiter.sv - self-checking bench for cv32e40p_data_port_arbiter
module tb_cv32e40p_data_port_arbiter;

  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  m_req_i = '0;
  logic [63:0] m_addr_i = '0;
  logic [1:0]  m_we_i = '0;
  logic [7:0]  m_be_i = '0;
  logic [63:0] m_wdata_i = '0;
  logic [1:0]  m_gnt_o;
  logic [1:0]  m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [3:0]  outstanding_o;
  logic        err_o;

  cv32e40p_data_port_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .m_req_i      (m_req_i),
    .m_addr_i     (m_addr_i),
    .m_we_i       (m_we_i),
    .m_be_i       (m_be_i),
    .m_wdata_i    (m_wdata_i),
    .m_gnt_o      (m_gnt_o),
    .m_rvalid_o   (m_rvalid_o),
    .m_rdata_o    (m_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .outstanding_o(outstanding_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: owner list of outstanding transactions, priority holder, lock owner.
  int          owner_q[$];
  bit          prio;
  bit          locked;
  bit          locked_who;
  bit          err_m;
  logic [31:0] a_addr  [2];
  logic [31:0] a_wdata [2];
  logic        a_we    [2];
  logic [3:0]  a_be    [2];

  logic [1:0]  obs_gnt;
  logic [1:0]  obs_rv;
  logic        obs_req;
  logic [31:0] obs_addr;
  logic [31:0] obs_rdata;
  logic [3:0]  obs_out;
  logic        obs_err;

  task automatic step(input logic rst, input logic [1:0] req, input logic gnt,
                      input logic rv, input logic [31:0] rd);
    bit         full;
    logic [1:0] elig;
    bit         sel;
    bit         exp_req;
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
    bit         can_pop;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!(locked && locked_who == m)) begin
        a_addr[m]  = $urandom;
        a_wdata[m] = $urandom;
        a_we[m]    = 1'($urandom_range(0, 1));
        a_be[m]    = 4'($urandom_range(0, 15));
      end
    end
    rst_i        = rst;
    m_req_i      = req;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    m_addr_i     = {a_addr[1], a_addr[0]};
    m_wdata_i    = {a_wdata[1], a_wdata[0]};
    m_we_i       = {a_we[1], a_we[0]};
    m_be_i       = {a_be[1], a_be[0]};
    #1;
    full = (owner_q.size() == MAX_OUT);
    elig = full ? 2'b00 : req;
    if (locked)              sel = locked_who;
    else if (elig == 2'b11)  sel = prio;
    else                     sel = elig[1];
    exp_req = !rst && elig[sel];
    exp_gnt = (exp_req && gnt) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    can_pop = !rst && rv && owner_q.size() > 0;
    exp_rv  = can_pop ? (owner_q[0] == 1 ? 2'b10 : 2'b01) : 2'b00;

    check("mem_req", 64'(mem_req_o), 64'(exp_req));
    check("m_gnt", 64'(m_gnt_o), 64'(exp_gnt));
    check("m_rvalid", 64'(m_rvalid_o), 64'(exp_rv));
    check("m_rdata", 64'(m_rdata_o), 64'(rd));
    if (exp_req) begin
      check("mem_addr", 64'(mem_addr_o), 64'(a_addr[sel]));
      check("mem_wdata", 64'(mem_wdata_o), 64'(a_wdata[sel]));
      check("mem_we", 64'(mem_we_o), 64'(a_we[sel]));
      check("mem_be", 64'(mem_be_o), 64'(a_be[sel]));
    end
    if (!rst) begin
      check("outstanding", 64'(outstanding_o), 64'(owner_q.size()));
      check("err", 64'(err_o), 64'(err_m));
    end

    obs_gnt   = m_gnt_o;
    obs_rv    = m_rvalid_o;
    obs_req   = mem_req_o;
    obs_addr  = mem_addr_o;
    obs_rdata = m_rdata_o;
    obs_out   = outstanding_o;
    obs_err   = err_o;

    if (rst) begin
      owner_q.delete();
      prio   = 1'b0;
      locked = 1'b0;
      err_m  = 1'b0;
    end else begin
      if (rv && owner_q.size() == 0) err_m = 1'b1;
      if (can_pop) void'(owner_q.pop_front());
      if (exp_gnt != 2'b00) begin
        owner_q.push_back(int'(sel));
        prio   = !sel;
        locked = 1'b0;
      end else if (exp_req) begin
        locked     = 1'b1;
        locked_who = sel;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  logic [31:0] held_addr;
  logic [1:0]  gnt_seq [4];
  logic [1:0]  rv_seq  [5];
  logic [1:0]  rreq;
  logic        rrv;

  initial begin
    prio = 0; locked = 0; locked_who = 0; err_m = 0;

    // 1: single LSU read
    do_reset();
    check("t1_outstanding_after_reset", 64'(outstanding_o), 64'd0);
    check("t1_err_after_reset", 64'(err_o), 64'd0);
    step(1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
    check("t1_gnt", 64'(obs_gnt), 64'h1);
    step(1'b0, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
    check("t1_rvalid", 64'(obs_rv), 64'h1);
    check("t1_rdata", 64'(obs_rdata), 64'hDEADBEEF);
    check("t1_out_before", 64'(obs_out), 64'd1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    check("t1_out_after", 64'(obs_out), 64'd0);

    // 2: both masters requesting, alternating grants, responses one cycle later
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i < 4) ? 2'b11 : 2'b00, 1'b1, (i > 0), $urandom);
      if (i < 4) gnt_seq[i] = obs_gnt;
      rv_seq[i] = obs_rv;
    end
    check("t2_gnt0", 64'(gnt_seq[0]), 64'h1);
    check("t2_gnt1", 64'(gnt_seq[1]), 64'h2);
    check("t2_gnt2", 64'(gnt_seq[2]), 64'h1);
    check("t2_gnt3", 64'(gnt_seq[3]), 64'h2);
    check("t2_rv1", 64'(rv_seq[1]), 64'h1);
    check("t2_rv2", 64'(rv_seq[2]), 64'h2);
    check("t2_rv3", 64'(rv_seq[3]), 64'h1);
    check("t2_rv4", 64'(rv_seq[4]), 64'h2);

    // 3: stalled master 1 keeps the port and its address until granted
    do_reset();
    step(1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    held_addr = a_addr[1];
    check("t3_req", 64'(obs_req), 64'h1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
      check("t3_addr_stable", 64'(obs_addr), 64'(held_addr));
    end
    step(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    check("t3_m1_first", 64'(obs_gnt), 64'h2);
    check("t3_m1_addr", 64'(obs_addr), 64'(held_addr));
    step(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    check("t3_m0_next", 64'(obs_gnt), 64'h1);
    step(1'b0, 2'b00, 1'b0, 1'b1, 32'h1);
    step(1'b0, 2'b00, 1'b0, 1'b1, 32'h2);

    // 4: full FIFO blocks requests, even with a response in the same cycle
    do_reset();
    step(1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
    step(1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
    step(1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
    check("t4_blocked", 64'(obs_req), 64'h0);
    check("t4_full", 64'(obs_out), 64'd2);
    step(1'b0, 2'b01, 1'b1, 1'b1, 32'h5);
    check("t4_blocked_on_pop", 64'(obs_req), 64'h0);
    check("t4_pop_rv", 64'(obs_rv), 64'h1);
    step(1'b0, 2'b01, 1'b0, 1'b0, 32'h0);
    check("t4_req_again", 64'(obs_req), 64'h1);
    step(1'b0, 2'b01, 1'b1, 1'b1, 32'h6);
    step(1'b0, 2'b00, 1'b0, 1'b1, 32'h7);

    // 5: spurious response sets sticky error
    do_reset();
    step(1'b0, 2'b00, 1'b0, 1'b1, 32'h9);
    check("t5_no_rv", 64'(obs_rv), 64'h0);
    check("t5_err_not_yet", 64'(obs_err), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
      check("t5_err_sticky", 64'(obs_err), 64'h1);
    end

    // 6: reset with outstanding transaction and a locked request
    do_reset();
    step(1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
    step(1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    step(1'b1, 2'b11, 1'b1, 1'b1, 32'h0);
    check("t6_rst_gnt", 64'(obs_gnt), 64'h0);
    check("t6_rst_rv", 64'(obs_rv), 64'h0);
    check("t6_rst_req", 64'(obs_req), 64'h0);
    step(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    check("t6_out_zero", 64'(obs_out), 64'd0);
    check("t6_m0_prio", 64'(obs_gnt), 64'h1);
    check("t6_err_clear", 64'(obs_err), 64'h0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rreq = 2'($urandom_range(0, 3));
      if (locked) rreq[locked_who] = 1'b1;
      rrv = (owner_q.size() > 0) && ($urandom_range(0, 1) == 1);
      step(($urandom_range(0, 199) == 0), rreq, 1'($urandom_range(0, 1)), rrv, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
